// File: rtl/header_pin_exerciser_if.sv
// Host/pad bundle for the header pin exerciser.
// Carries the run control/status signals and the pad drive/readback vectors.
// slave = the exerciser itself, master = host logic plus pad model.
interface header_pin_exerciser_if #(
  parameter int NPINS = 56,
  parameter int ERRW  = 8
) ();
  logic             start;
  logic [1:0]       mode;
  logic [NPINS-1:0] pin_in;
  logic [NPINS-1:0] pin_out;
  logic [NPINS-1:0] pin_oe;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERRW-1:0]  err_cnt;
  logic [5:0]       fail_idx;

  modport slave (
    input  start, mode, pin_in,
    output pin_out, pin_oe, busy, done, pass, err_cnt, fail_idx
  );

  modport master (
    output start, mode, pin_in,
    input  pin_out, pin_oe, busy, done, pass, err_cnt, fail_idx
  );
endinterface

// File: rtl/header_pin_exerciser.sv
// Purpose: drive header pads with walking-1/walking-0/all-1-all-0 patterns, read back, count mismatching steps.
// Latency: start at edge T -> done at edge T + steps*(SETTLE+2) + 1; each step is DRIVE, SETTLE cycles, SAMPLE.
// Backpressure: none; start is ignored unless IDLE. Optional macro PINTEST_LOOP_EN: held start re-runs back to back.
module header_pin_exerciser #(
  parameter int NPINS  = 56,
  parameter int SETTLE = 15,
  parameter int ERRW   = 8
) (
  input  logic                      gck1,
  input  logic                      gsr,
  header_pin_exerciser_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       step_q, step_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NPINS-1:0] pin_out_q, pin_out_d;
  logic [NPINS-1:0] pin_oe_q, pin_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic [5:0]       fail_idx_q, fail_idx_d;

  logic [NPINS-1:0] one_hot;
  logic [NPINS-1:0] pattern;
  logic [5:0]       last_step;

  // Pattern for the current step of the latched mode; mode 11 behaves as walking-one.
  always_comb begin
    one_hot   = NPINS'(1) << step_q;
    pattern   = one_hot;
    last_step = 6'(NPINS - 1);
    case (mode_q)
      2'b01:   pattern = ~one_hot;
      2'b10: begin
        pattern   = (step_q == 6'd0) ? '1 : '0;
        last_step = 6'd1;
      end
      default: pattern = one_hot;
    endcase
  end

  // Next-state and datapath updates for the run sequencer.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    pin_out_d  = pin_out_q;
    pin_oe_d   = pin_oe_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          err_cnt_d  = '0;
          fail_idx_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          step_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        pin_oe_d  = '1;
        pin_out_d = pattern;
        cnt_d     = 8'(SETTLE);
        // Ends the one-cycle done pulse when runs are chained back to back.
        done_d    = 1'b0;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.pin_in != pin_out_q) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (err_cnt_q == '0) begin
            fail_idx_d = step_q;
          end
        end
        if (step_q == last_step) begin
          state_d = S_FINISH;
        end else begin
          step_d  = step_q + 6'd1;
          state_d = S_DRIVE;
        end
      end
      S_FINISH: begin
        pin_oe_d  = '0;
        pin_out_d = '0;
        done_d    = 1'b1;
        pass_d    = (err_cnt_q == '0);
`ifdef PINTEST_LOOP_EN
        // Held start chains another pass; error history keeps accumulating.
        if (bus.start) begin
          step_d  = '0;
          state_d = S_DRIVE;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
`else
        busy_d  = 1'b0;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset tristates the pads on the same edge.
  always_ff @(posedge gck1) begin
    if (!gsr) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
      pin_out_q  <= '0;
      pin_oe_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      pin_out_q  <= pin_out_d;
      pin_oe_q   <= pin_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign bus.pin_out  = pin_out_q;
  assign bus.pin_oe   = pin_oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.fail_idx = fail_idx_q;

endmodule

// File: tb/tb_header_pin_exerciser.sv
// Directed bench for header_pin_exerciser (NPINS=8, SETTLE=2).
// Pad patterns are scoreboarded; done latency and result registers checked per run.
// A second instance with ERRW=2 covers counter saturation.
module tb_header_pin_exerciser;

  logic gck1 = 1'b0;
  logic gsr;
  always #5 gck1 = ~gck1;

  header_pin_exerciser_if #(.NPINS(8), .ERRW(8)) bus ();
  header_pin_exerciser_if #(.NPINS(8), .ERRW(2)) bus2 ();

  header_pin_exerciser #(.NPINS(8), .SETTLE(2), .ERRW(8)) dut (
    .gck1 (gck1),
    .gsr  (gsr),
    .bus  (bus)
  );

  header_pin_exerciser #(.NPINS(8), .SETTLE(2), .ERRW(2)) dut2 (
    .gck1 (gck1),
    .gsr  (gsr),
    .bus  (bus2)
  );

  // Pad model: loopback with optional stuck-at-0 pins and a 5/6 wired-AND bridge.
  logic [7:0] stuck0;
  logic       bridge_en;
  logic [7:0] lb;
  always_comb begin
    lb = bus.pin_out & ~stuck0;
    if (bridge_en) begin
      lb[5] = lb[5] & lb[6];
      lb[6] = lb[5];
    end
  end
  assign bus.pin_in  = lb;
  assign bus2.pin_in = 8'h00;

`ifdef PINTEST_LOOP_EN
  localparam int FIN_PULSE = 0;
`else
  localparam int FIN_PULSE = 32;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [1:0] m, input int k);
    logic [7:0] oh;
    oh = 8'h01 << k;
    case (m)
      2'b01:   return ~oh;
      2'b10:   return (k == 0) ? 8'hff : 8'h00;
      default: return oh;
    endcase
  endfunction

  // One run on the selected instance; pulse_at injects a start pulse (and a mode change) mid-run.
  task automatic run(input bit sel, input logic [1:0] m, input int exp_lat,
                     input logic [7:0] exp_err, input logic [5:0] exp_idx,
                     input logic exp_pass, input string tag, input int pulse_at);
    int         steps;
    int         got;
    logic [7:0] prev_out, prev_oe, cur_out, cur_oe, e;
    logic       cur_done;
    steps = (m == 2'b10) ? 2 : 8;
    for (int k = 0; k < steps; k++) exp_q.push_back(pat(m, k));
    prev_out = sel ? bus2.pin_out : bus.pin_out;
    prev_oe  = sel ? bus2.pin_oe  : bus.pin_oe;
    @(negedge gck1);
    if (sel) begin bus2.mode = m; bus2.start = 1'b1; end
    else     begin bus.mode  = m; bus.start  = 1'b1; end
    @(negedge gck1);
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    got = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge gck1);
      #1;
      bus.start  = 1'b0;
      bus2.start = 1'b0;
      cur_out  = sel ? bus2.pin_out : bus.pin_out;
      cur_oe   = sel ? bus2.pin_oe  : bus.pin_oe;
      cur_done = sel ? bus2.done    : bus.done;
      if (cur_oe != 8'h00 && (cur_oe != prev_oe || cur_out != prev_out)) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL %s_sb_extra observed=%0h expected=none", tag, cur_out);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_pat"}, 64'(cur_out), 64'(e));
          chk({tag, "_oe"}, 64'(cur_oe), 64'hff);
        end
      end
      prev_out = cur_out;
      prev_oe  = cur_oe;
      if (cur_done) begin
        got = n;
        break;
      end
      if (n == pulse_at) begin
        if (sel) begin bus2.start = 1'b1; bus2.mode = ~m; end
        else     begin bus.start  = 1'b1; bus.mode  = ~m; end
      end
    end
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    chk({tag, "_done_lat"}, 64'(got), 64'(exp_lat));
    chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk({tag, "_err"}, sel ? 64'(bus2.err_cnt) : 64'(bus.err_cnt), 64'(exp_err));
    chk({tag, "_idx"}, sel ? 64'(bus2.fail_idx) : 64'(bus.fail_idx), 64'(exp_idx));
    chk({tag, "_pass"}, sel ? 64'(bus2.pass) : 64'(bus.pass), 64'(exp_pass));
    @(posedge gck1);
    #1;
    chk({tag, "_busy_after"}, sel ? 64'(bus2.busy) : 64'(bus.busy), 64'd0);
    chk({tag, "_done_hold"}, sel ? 64'(bus2.done) : 64'(bus.done), 64'd1);
    chk({tag, "_err_hold"}, sel ? 64'(bus2.err_cnt) : 64'(bus.err_cnt), 64'(exp_err));
  endtask

  initial begin
    gsr        = 1'b0;
    bus.start  = 1'b0;
    bus.mode   = 2'b00;
    bus2.start = 1'b0;
    bus2.mode  = 2'b00;
    stuck0     = 8'h00;
    bridge_en  = 1'b0;
    repeat (3) @(posedge gck1);
    #1;
    chk("rst_oe", 64'(bus.pin_oe), 64'h0);
    chk("rst_out", 64'(bus.pin_out), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_err", 64'(bus.err_cnt), 64'd0);
    chk("rst_idx", 64'(bus.fail_idx), 64'd0);
    @(negedge gck1);
    gsr = 1'b1;

    // Reset mid-run after an error has been counted.
    stuck0 = 8'h01;
    @(negedge gck1);
    bus.mode  = 2'b00;
    bus.start = 1'b1;
    @(negedge gck1);
    bus.start = 1'b0;
    repeat (8) @(posedge gck1);
    #1;
    chk("midrun_busy", 64'(bus.busy), 64'd1);
    chk("midrun_err", 64'(bus.err_cnt), 64'd1);
    gsr = 1'b0;
    @(posedge gck1);
    #1;
    chk("abort_oe", 64'(bus.pin_oe), 64'h0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_err", 64'(bus.err_cnt), 64'd0);
    @(posedge gck1);
    #1;
    gsr = 1'b1;
    stuck0 = 8'h00;

    // Clean walking-one; start coincident with FINISH must not retrigger.
    run(1'b0, 2'b00, 33, 8'd0, 6'd0, 1'b1, "m00_clean", FIN_PULSE);
    // Mode 11 behaves as walking-one.
    run(1'b0, 2'b11, 33, 8'd0, 6'd0, 1'b1, "m11_clean", 0);
    // Pin 3 stuck low.
    stuck0 = 8'h08;
    run(1'b0, 2'b00, 33, 8'd1, 6'd3, 1'b0, "m00_stuck3", 0);
    stuck0 = 8'h00;
    // Bridge 5/6: invisible to all-1/all-0, caught by walking-one.
    bridge_en = 1'b1;
    run(1'b0, 2'b10, 9, 8'd0, 6'd0, 1'b1, "m10_bridge", 0);
    run(1'b0, 2'b00, 33, 8'd2, 6'd5, 1'b0, "m00_bridge", 0);
    bridge_en = 1'b0;
    // Saturating 2-bit counter; start and mode change mid-run ignored.
    run(1'b1, 2'b01, 33, 8'd3, 6'd0, 1'b0, "m01_sat", 10);

`ifdef PINTEST_LOOP_EN
    // Held start chains runs: done pulses every 9 cycles, busy stays high.
    @(negedge gck1);
    bus.mode  = 2'b10;
    bus.start = 1'b1;
    @(negedge gck1);
    for (int n = 1; n <= 30; n++) begin
      @(posedge gck1);
      #1;
      if (n == 20) bus.start = 1'b0;
      chk($sformatf("loop_done_%0d", n), 64'(bus.done),
          64'((n == 9 || n == 18 || n >= 27) ? 1 : 0));
      chk($sformatf("loop_busy_%0d", n), 64'(bus.busy), 64'((n < 27) ? 1 : 0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
